// File: rtl/uart_tx_engine_if.sv
// Producer-side handshake bundle for uart_tx_engine: one word plus its
// per-frame framing options, exchanged under a valid/ready handshake.
interface uart_tx_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [1:0]            parity_mode;
  logic                  two_stop;

  modport master (
    output tx_data,
    output tx_valid,
    output parity_mode,
    output two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  parity_mode,
    input  two_stop,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises one captured word per frame, LSB first, with
// optional even/odd parity and one or two stop bits, at CLKS_PER_BIT clocks/bit.
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               system_clk,
  input  logic               system_reset,
  uart_tx_engine_if.slave    tx_if,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_serial_data
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        baud_cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    two_stop_q;
  logic                    stop_idx_q;
  logic                    baud_last;
  logic                    accept;

  assign tx_if.tx_ready = (state == S_IDLE) && !system_reset;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign baud_last      = (baud_cnt == CNT_LAST);

  // Frame sequencer; the line level for the next slot is registered at each slot boundary.
  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state          <= S_IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
      two_stop_q     <= 1'b0;
      stop_idx_q     <= 1'b0;
      tx_serial_data <= 1'b1;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_cnt       <= '0;
          bit_idx        <= '0;
          stop_idx_q     <= 1'b0;
          tx_serial_data <= 1'b1;
          if (accept) begin
            shift_q        <= tx_if.tx_data;
            par_en_q       <= (tx_if.parity_mode == PAR_EVEN) ||
                              (tx_if.parity_mode == PAR_ODD);
            par_bit_q      <= (^tx_if.tx_data) ^ (tx_if.parity_mode == PAR_ODD);
            two_stop_q     <= tx_if.two_stop;
            tx_serial_data <= 1'b0;
            tx_busy        <= 1'b1;
            state          <= S_START;
          end
        end

        S_START: begin
          if (baud_last) begin
            baud_cnt       <= '0;
            bit_idx        <= '0;
            tx_serial_data <= shift_q[0];
            state          <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              if (par_en_q) begin
                tx_serial_data <= par_bit_q;
                state          <= S_PARITY;
              end else begin
                tx_serial_data <= 1'b1;
                stop_idx_q     <= 1'b0;
                state          <= S_STOP;
              end
            end else begin
              bit_idx        <= bit_idx + BIT_W'(1);
              shift_q        <= shift_q >> 1;
              tx_serial_data <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (baud_last) begin
            baud_cnt       <= '0;
            stop_idx_q     <= 1'b0;
            tx_serial_data <= 1'b1;
            state          <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          tx_serial_data <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (two_stop_q && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              stop_idx_q <= 1'b0;
              tx_busy    <= 1'b0;
              tx_done    <= 1'b1;
              state      <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // Unreachable encodings recover to an idle, high line.
        default: begin
          state          <= S_IDLE;
          baud_cnt       <= '0;
          bit_idx        <= '0;
          stop_idx_q     <= 1'b0;
          tx_serial_data <= 1'b1;
          tx_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed and random frames compared cycle by cycle
// against a bit-list model of the serial frame.
module tb_uart_tx_engine;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;

  logic system_clk;
  logic system_reset;
  logic tx_busy;
  logic tx_done;
  logic tx_serial_data;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_engine_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_engine #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .system_clk    (system_clk),
    .system_reset  (system_reset),
    .tx_if         (bus.slave),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_serial_data(tx_serial_data)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Idle-line checks for n cycles (tx_valid must already be low).
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge system_clk);
      check("idle_line",  tx_serial_data, 1);
      check("idle_busy",  tx_busy,        0);
      check("idle_done",  tx_done,        0);
      check("idle_ready", bus.tx_ready,   1);
    end
  endtask

  // Reference frame as a list of bit slots.
  task automatic build_frame(input logic [DW-1:0] word, input logic [1:0] mode,
                             input logic ts, output bit slots[$]);
    slots = {};
    slots.push_back(1'b0);
    for (int i = 0; i < DW; i++) slots.push_back(word[i]);
    if (mode == 2'b01) slots.push_back(^word);
    if (mode == 2'b10) slots.push_back(~^word);
    slots.push_back(1'b1);
    if (ts) slots.push_back(1'b1);
  endtask

  // Called at a negedge of an idle/done cycle; returns at the negedge of the tx_done cycle.
  task automatic run_frame(input logic [DW-1:0] word, input logic [1:0] mode, input logic ts,
                           input bit hold, input bit mutate);
    bit slots[$];
    int frame_len;
    build_frame(word, mode, ts, slots);
    frame_len = slots.size() * CPB;
    bus.tx_data     = word;
    bus.parity_mode = mode;
    bus.two_stop    = ts;
    bus.tx_valid    = 1'b1;
    check("accept_ready", bus.tx_ready, 1);
    @(posedge system_clk);
    #1;
    if (!hold) bus.tx_valid = 1'b0;
    for (int i = 0; i < frame_len; i++) begin
      @(negedge system_clk);
      check($sformatf("line_w%02h_m%0d_s%0d_c%0d", word, mode, ts, i),
            tx_serial_data, slots[i / CPB]);
      check("frame_busy",  tx_busy,      1);
      check("frame_done",  tx_done,      0);
      check("frame_ready", bus.tx_ready, 0);
      if (mutate && i == 2 * CPB) begin
        bus.tx_data     = DW'($urandom);
        bus.parity_mode = 2'($urandom);
        bus.two_stop    = 1'($urandom);
        if (!hold) bus.tx_valid = 1'($urandom);
      end
      if (i == frame_len - 1 && !hold) bus.tx_valid = 1'b0;
    end
    @(negedge system_clk);
    check("end_done",  tx_done,        1);
    check("end_busy",  tx_busy,        0);
    check("end_line",  tx_serial_data, 1);
    check("end_ready", bus.tx_ready,   1);
  endtask

  initial begin
    bit slots[$];
    system_reset    = 1'b1;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = '0;
    bus.parity_mode = 2'b00;
    bus.two_stop    = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge system_clk);
      check("rst_line",  tx_serial_data, 1);
      check("rst_ready", bus.tx_ready,   0);
      check("rst_busy",  tx_busy,        0);
      check("rst_done",  tx_done,        0);
    end
    system_reset = 1'b0;
    idle_cycles(20);

    // Basic frame, then the parity variants.
    run_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    run_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_frame(8'hA5, 2'b10, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_frame(8'h07, 2'b01, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Two stop bits with odd parity, inputs disturbed mid-frame.
    run_frame(8'h00, 2'b10, 1'b1, 1'b0, 1'b1);
    idle_cycles(1);

    // Back-to-back with tx_valid held high throughout frame 1.
    run_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1);
    run_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // Reset during data slot 3 aborts the frame.
    build_frame(8'h5A, 2'b00, 1'b0, slots);
    bus.tx_data     = 8'h5A;
    bus.parity_mode = 2'b00;
    bus.two_stop    = 1'b0;
    bus.tx_valid    = 1'b1;
    @(posedge system_clk);
    #1;
    bus.tx_valid = 1'b0;
    for (int i = 0; i <= int'(CPB) * 4 + 1; i++) begin
      @(negedge system_clk);
      check("abort_pre_line", tx_serial_data, slots[i / CPB]);
    end
    system_reset = 1'b1;
    @(negedge system_clk);
    check("abort_line",  tx_serial_data, 1);
    check("abort_busy",  tx_busy,        0);
    check("abort_done",  tx_done,        0);
    check("abort_ready", bus.tx_ready,   0);
    system_reset = 1'b0;
    @(negedge system_clk);
    check("post_rst_ready", bus.tx_ready,   1);
    check("post_rst_done",  tx_done,        0);
    check("post_rst_line",  tx_serial_data, 1);
    idle_cycles(2);
    run_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Random frames with random gaps (gap 0 is back-to-back from the done cycle).
    for (int f = 0; f < 12; f++) begin
      run_frame(DW'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
